iq_dispatch: RTL
================

Name: iq_dispatch

Overview:
- Writer side of the 16-entry centralized issue queue (ciq); the issue stage and its four age-based arbiters read the queue.
- Owns ciq storage and accepts one renamed instruction per cycle from rename/dispatch. It allocates the lowest free slot and applies writeback wakeups to source-ready bits.
- Maintains per-entry ages and releases slots granted by the issue arbiters.
- Drives the flattened ciq vector that the issue stage consumes.

Parameters:
OPCODE_WIDTH, 7, opcode field width
PRF_WIDTH, 6, physical register tag width
AGE_WIDTH, 5, per-entry age counter width
IQ_DEPTH, 16, number of entries (index width 4)
IQ_WIDTH, 35, entry width. Layout, LSB first: FREE[0], ISSUED[1], AGE[6:2], PRDV[7], PRD[13:8], PRS2_RDY[14], PRS2[20:15], PRS1_RDY[21], PRS1[27:22], OP[34:28]
WB_PORTS, 2, number of wakeup broadcast ports

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  discard all entries (branch mispredict/exception)
disp_valid  in  1  dispatch request
disp_ready  out  1  queue can accept this cycle
disp_op  in  7  opcode
disp_prs1  in  6  source 1 tag
disp_prs1_rdy  in  1  source 1 already ready (or unused)
disp_prs2  in  6  source 2 tag
disp_prs2_rdy  in  1  source 2 already ready (or unused)
disp_prdv  in  1  destination valid
disp_prd  in  6  destination tag
wb_valid  in  2  per-port wakeup valid
wb_prd  in  12  per-port wakeup tag (port k at [6k+5:6k])
gnt_valid  in  4  grants from ALU0, ALU1, MUL, LS arbiters
gnt_idx  in  16  granted entry index per port (port k at [4k+3:4k])
ciq_flat  out  560  entry i at [35i+34:35i]
iq_count  out  5  occupied entries, 0..16
iq_full  out  1  iq_count==16

Behaviour:
- Reset (rst=1 at clk edge): every entry has FREE=1 and all other bits 0. iq_count=0, iq_full=0, disp_ready=1.
- flush: same effect as reset on the next edge. flush has priority over dispatch, wakeup and grant in that cycle.
- disp_ready = ~iq_full. It is computed from registered state only; it does not account for same-cycle frees.
- Dispatch fires when disp_valid & disp_ready.
  - Target slot: lowest-index entry with FREE=1.
  - The slot is written at the edge: FREE=0, ISSUED=0, AGE=0, with fields copied from the disp_* inputs.
  - A dispatch with disp_ready=0 is dropped with no state change. The producer must hold its request.
- Wakeup: for each port k with wb_valid[k], every occupied entry whose PRS1 (or PRS2) equals wb_prd[k] gets the matching RDY bit set at the edge.
  - Wakeup also applies to the entry being dispatched in the same cycle (bypass). Its RDY bit = disp_rdy | tag match.
  - RDY bits are never cleared except by free, reset or flush.
- Grant, two-stage:
  - Edge N: for each port with gnt_valid, the entry at gnt_idx gets ISSUED=1. Its operand fields stay stable so the issue stage can read them on cycle N+1.
  - Edge N+1: any entry with ISSUED=1 becomes FREE=1, ISSUED=0, AGE=0.
  - A grant to an entry that is already free or already issued is ignored.
  - Two ports granting the same index in one cycle is illegal; flag it with a simulation assertion.
- Age: each edge, every occupied entry (FREE=0, including ISSUED) increments AGE, saturating at 31. A newly written entry starts at 0.
- Free and reuse:
  - A slot freed at edge N+1 is not allocatable until cycle N+1, because allocation uses registered FREE.
  - Dispatch and free events in the same cycle are independent.
  - iq_count(next) = iq_count + dispatch_fire − entries_freed_this_edge.
- ciq_flat and iq_count are registered and directly reflect entry state; there is no combinational path from inputs to ciq_flat.
- Latency:
  - A dispatched entry is visible on ciq_flat one cycle after the fire.
  - A wakeup is visible one cycle after wb_valid.

Test Plan:
1. Reset, then 16 back-to-back dispatches with disp_valid=1 -> entries 0..15 filled in order. iq_count=16, iq_full=1, disp_ready=0; a 17th request is dropped with no entry change.
2. Dispatch prs1=6'd12 with rdy=0 while wb_valid=2'b01, wb_prd[5:0]=12 in the same cycle -> the entry appears with PRS1_RDY=1. A later wb_prd=12 on port 1 for another waiting entry -> PRS1_RDY=1 one cycle later.
3. Fill entries 0..3, then gnt_valid=4'b0101 with idx 1 (port 0) and 3 (port 2) -> next cycle entries 1 and 3 have ISSUED=1. The following cycle they are FREE=1 and iq_count drops 4->2. The next dispatch lands in entry 1.
4. Hold one entry occupied for 40 cycles -> AGE reads 0,1,…,31 and then stays at 31. A newly dispatched entry next to it starts at AGE=0.
5. With 10 entries occupied, assert flush together with disp_valid and a grant -> next cycle all entries are FREE=1, iq_count=0, and no new entry is written.
6. Full queue, a grant on entry 5, and disp_valid held -> disp_ready rises only after entry 5 is freed. The dispatch then lands in entry 5 and iq_count returns to 16.

Source files
------------

// File: rtl/iq_dispatch.sv
// iq_dispatch: writer side of the centralized issue queue.
// Allocates the lowest free slot for each dispatched instruction, applies
// writeback wakeups to source-ready bits, ages occupied entries, retires
// granted entries one cycle after the grant, and exposes every entry on a
// flat registered vector.
module iq_dispatch #(
  parameter int OPCODE_WIDTH = 7,
  parameter int PRF_WIDTH    = 6,
  parameter int AGE_WIDTH    = 5,
  parameter int IQ_DEPTH     = 16,
  parameter int IQ_WIDTH     = 35,
  parameter int WB_PORTS     = 2,
  parameter int GNT_PORTS    = 4,
  localparam int IDX_WIDTH   = $clog2(IQ_DEPTH),
  localparam int CNT_WIDTH   = $clog2(IQ_DEPTH + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            disp_valid,
  output logic                            disp_ready,
  input  logic [OPCODE_WIDTH-1:0]         disp_op,
  input  logic [PRF_WIDTH-1:0]            disp_prs1,
  input  logic                            disp_prs1_rdy,
  input  logic [PRF_WIDTH-1:0]            disp_prs2,
  input  logic                            disp_prs2_rdy,
  input  logic                            disp_prdv,
  input  logic [PRF_WIDTH-1:0]            disp_prd,
  input  logic [WB_PORTS-1:0]             wb_valid,
  input  logic [WB_PORTS*PRF_WIDTH-1:0]   wb_prd,
  input  logic [GNT_PORTS-1:0]            gnt_valid,
  input  logic [GNT_PORTS*IDX_WIDTH-1:0]  gnt_idx,
  output logic [IQ_DEPTH*IQ_WIDTH-1:0]    ciq_flat,
  output logic [CNT_WIDTH-1:0]            iq_count,
  output logic                            iq_full
);

  // Field order (MSB first) matches the entry layout the issue stage decodes.
  typedef struct packed {
    logic [OPCODE_WIDTH-1:0] op;
    logic [PRF_WIDTH-1:0]    prs1;
    logic                    prs1_rdy;
    logic [PRF_WIDTH-1:0]    prs2;
    logic                    prs2_rdy;
    logic [PRF_WIDTH-1:0]    prd;
    logic                    prdv;
    logic [AGE_WIDTH-1:0]    age;
    logic                    issued;
    logic                    free;
  } entry_t;

  localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(IQ_DEPTH);

  entry_t entry_q [IQ_DEPTH];
  entry_t entry_d [IQ_DEPTH];

  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;

  logic                 alloc_found;
  logic [IDX_WIDTH-1:0] alloc_idx;
  logic                 disp_fire;
  logic [IQ_DEPTH-1:0]  gnt_hit;
  logic [CNT_WIDTH-1:0] free_cnt;
  logic                 dup_grant;

  function automatic entry_t empty_entry();
    entry_t e;
    e      = '0;
    e.free = 1'b1;
    return e;
  endfunction

  // A tag is woken when any valid writeback port broadcasts it this cycle.
  function automatic logic wb_hit(input logic [PRF_WIDTH-1:0]          tag,
                                  input logic [WB_PORTS-1:0]           valid,
                                  input logic [WB_PORTS*PRF_WIDTH-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < WB_PORTS; k++) begin
      if (valid[k] && (tags[k*PRF_WIDTH +: PRF_WIDTH] == tag)) begin
        hit = 1'b1;
      end
    end
    return hit;
  endfunction

  // Full/ready come from the registered count only, never from same-cycle frees.
  always_comb begin
    iq_full    = (count_q == CNT_FULL);
    disp_ready = ~iq_full;
    iq_count   = count_q;
  end

  // Lowest-index free slot; scanning downward leaves the smallest index last.
  always_comb begin
    alloc_found = 1'b0;
    alloc_idx   = '0;
    for (int i = IQ_DEPTH - 1; i >= 0; i--) begin
      if (entry_q[i].free) begin
        alloc_found = 1'b1;
        alloc_idx   = IDX_WIDTH'(i);
      end
    end
    disp_fire = disp_valid & disp_ready & alloc_found & ~flush;
  end

  // Decode the arbiter grants into a per-entry hit mask and spot collisions.
  always_comb begin
    gnt_hit   = '0;
    dup_grant = 1'b0;
    for (int p = 0; p < GNT_PORTS; p++) begin
      if (gnt_valid[p]) begin
        gnt_hit[gnt_idx[p*IDX_WIDTH +: IDX_WIDTH]] = 1'b1;
      end
      for (int q = p + 1; q < GNT_PORTS; q++) begin
        if (gnt_valid[p] && gnt_valid[q] &&
            (gnt_idx[p*IDX_WIDTH +: IDX_WIDTH] == gnt_idx[q*IDX_WIDTH +: IDX_WIDTH])) begin
          dup_grant = 1'b1;
        end
      end
    end
  end

  // Entries issued last edge are the ones released on this edge.
  always_comb begin
    free_cnt = '0;
    for (int i = 0; i < IQ_DEPTH; i++) begin
      free_cnt = free_cnt + CNT_WIDTH'(entry_q[i].issued);
    end
  end

  // Per-entry next state: release, age/wakeup/grant, or fresh allocation.
  always_comb begin
    for (int i = 0; i < IQ_DEPTH; i++) begin
      entry_d[i] = entry_q[i];
      if (entry_q[i].issued) begin
        entry_d[i].free   = 1'b1;
        entry_d[i].issued = 1'b0;
        entry_d[i].age    = '0;
      end else if (!entry_q[i].free) begin
        if (entry_q[i].age != AGE_MAX) begin
          entry_d[i].age = entry_q[i].age + 1'b1;
        end
        if (wb_hit(entry_q[i].prs1, wb_valid, wb_prd)) begin
          entry_d[i].prs1_rdy = 1'b1;
        end
        if (wb_hit(entry_q[i].prs2, wb_valid, wb_prd)) begin
          entry_d[i].prs2_rdy = 1'b1;
        end
        if (gnt_hit[i]) begin
          entry_d[i].issued = 1'b1;
        end
      end else if (disp_fire && (alloc_idx == IDX_WIDTH'(i))) begin
        entry_d[i].free     = 1'b0;
        entry_d[i].issued   = 1'b0;
        entry_d[i].age      = '0;
        entry_d[i].op       = disp_op;
        entry_d[i].prs1     = disp_prs1;
        entry_d[i].prs1_rdy = disp_prs1_rdy | wb_hit(disp_prs1, wb_valid, wb_prd);
        entry_d[i].prs2     = disp_prs2;
        entry_d[i].prs2_rdy = disp_prs2_rdy | wb_hit(disp_prs2, wb_valid, wb_prd);
        entry_d[i].prdv     = disp_prdv;
        entry_d[i].prd      = disp_prd;
      end
      if (flush) begin
        entry_d[i] = empty_entry();
      end
    end
  end

  // Occupancy tracks allocations minus releases; flush empties the queue.
  always_comb begin
    count_d = count_q + CNT_WIDTH'(disp_fire) - free_cnt;
    if (flush) begin
      count_d = '0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < IQ_DEPTH; i++) begin
        entry_q[i] <= empty_entry();
      end
      count_q <= '0;
    end else begin
      for (int i = 0; i < IQ_DEPTH; i++) begin
        entry_q[i] <= entry_d[i];
      end
      count_q <= count_d;
    end
  end

  // Flatten the registered entries for the issue stage.
  always_comb begin
    ciq_flat = '0;
    for (int i = 0; i < IQ_DEPTH; i++) begin
      ciq_flat[i*IQ_WIDTH +: IQ_WIDTH] = entry_q[i];
    end
  end

`ifndef SYNTHESIS
  // Two arbiters must never pick the same slot in one cycle.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      assert (!dup_grant) else $error("iq_dispatch: two grant ports share one index");
    end
  end
`endif

endmodule
